// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   EX->MEM pipeline register that sits directly after the ALU. It captures the
//   ALU result, the zero flag and the EX control/data bundle. It passes them to
//   the data-memory stage through a valid/ready handshake.
//
//   A 2-entry skid buffer (main + skid) keeps in_ready a pure flop output.
//   Back-pressure from MEM therefore never makes a combinational path into EX.
//   The entry held in the main register also drives the EX forwarding bus.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               drop every held and incoming entry at the next edge
//   in_valid/in_ready   EX-side handshake (in_ready = skid register empty)
//   in_*                ALU result, zero flag, store data, rd, control bits
//   out_valid/out_ready MEM-side handshake
//   out_*               entry held in the main register
//   fwd_valid/rd/data   forwarding bus for the entry in the main register
//   occupancy           number of entries held (0..2)
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        occupancy
);

    // Payload layout: {result, zero, store_data, rd, reg_write, mem_read, mem_write}
    localparam int P_W = DATA_W + 1 + DATA_W + REG_W + 3;

    logic [P_W-1:0]    w_in_pl;
    logic [P_W-1:0]    r_main_pl;
    logic [P_W-1:0]    r_skid_pl;
    logic              r_main_valid;
    logic              r_skid_valid;
    logic              w_in_fire;
    logic              w_out_fire;

    logic [DATA_W-1:0] w_res;
    logic              w_zero;
    logic [DATA_W-1:0] w_sd;
    logic [REG_W-1:0]  w_rd;
    logic              w_rw;
    logic              w_mr;
    logic              w_mw;

    assign w_in_pl = {in_result, in_zero, in_store_data, in_rd,
                      in_reg_write, in_mem_read, in_mem_write};

    // in_ready depends only on the skid flop, never on out_ready.
    assign in_ready   = !r_skid_valid;
    assign out_valid  = r_main_valid;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_main_valid && out_ready;

    // ---- stage boundary: EX -> main/skid registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_pl    <= '0;
            r_skid_pl    <= '0;
        end else if (flush) begin
            // Payload is left as is; only the valid bits matter after a flush.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            case ({r_skid_valid, r_main_valid})
                2'b00: begin
                    if (w_in_fire) begin
                        r_main_pl    <= w_in_pl;
                        r_main_valid <= 1'b1;
                    end
                end
                2'b01: begin
                    if (w_out_fire && w_in_fire) begin
                        r_main_pl <= w_in_pl;
                    end else if (w_out_fire) begin
                        r_main_valid <= 1'b0;
                    end else if (w_in_fire) begin
                        // MEM stalled: park the new entry behind the main one.
                        r_skid_pl    <= w_in_pl;
                        r_skid_valid <= 1'b1;
                    end
                end
                2'b11: begin
                    // in_ready is low here, so only a drain can happen.
                    if (w_out_fire) begin
                        r_main_pl    <= r_skid_pl;
                        r_skid_valid <= 1'b0;
                    end
                end
                default: begin
                    // skid-only state is unreachable; hold.
                end
            endcase
        end
    end

    // ---- stage boundary: main register -> MEM outputs / forwarding ----
    assign {w_res, w_zero, w_sd, w_rd, w_rw, w_mr, w_mw} = r_main_pl;

    assign out_result     = w_res;
    assign out_zero       = w_zero;
    assign out_store_data = w_sd;
    assign out_rd         = w_rd;
    // Control bits of an empty slot are meaningless, so force them off.
    assign out_reg_write  = r_main_valid && w_rw;
    assign out_mem_read   = r_main_valid && w_mr;
    assign out_mem_write  = r_main_valid && w_mw;

    // Loads never forward; the hazard unit stalls on load-use instead.
    assign fwd_valid = r_main_valid && w_rw && !w_mr && (w_rd != '0);
    assign fwd_rd    = w_rd;
    assign fwd_data  = w_res;

    assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

    a_no_skid_only: assert property (@(posedge clk) disable iff (rst)
                                     !(r_skid_valid && !r_main_valid));

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [DATA_W-1:0] sd;
        logic [REG_W-1:0]  rd;
        logic              rw;
        logic              mr;
        logic              mw;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_zero;
    logic [DATA_W-1:0] in_store_data;
    logic [REG_W-1:0]  in_rd;
    logic              in_reg_write;
    logic              in_mem_read;
    logic              in_mem_write;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic [DATA_W-1:0] out_store_data;
    logic [REG_W-1:0]  out_rd;
    logic              out_reg_write;
    logic              out_mem_read;
    logic              out_mem_write;
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic [1:0]        occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_zero(in_zero), .in_store_data(in_store_data),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .occupancy(occupancy)
    );

    function automatic ent_t mk(input logic [DATA_W-1:0] res, input logic [REG_W-1:0] rd,
                                input logic rw, input logic mr);
        ent_t e;
        e.result = res; e.zero = (res == '0); e.sd = ~res; e.rd = rd;
        e.rw = rw; e.mr = mr; e.mw = 1'b0;
        return e;
    endfunction

    task automatic drive(input ent_t e, input logic v);
        in_valid      = v;
        in_result     = e.result;
        in_zero       = e.zero;
        in_store_data = e.sd;
        in_rd         = e.rd;
        in_reg_write  = e.rw;
        in_mem_read   = e.mr;
        in_mem_write  = e.mw;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(mk(32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0), 1'b1);
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || fwd_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b fwd_valid=%b occ=%0d, want 1 0 0 0",
                     in_ready, out_valid, fwd_valid, occupancy);
        end
        n_checks++;
        if (out_result !== '0 || out_rd !== '0 || out_store_data !== '0 || out_reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_payload: result=%h rd=%0d sd=%h rw=%b, want all 0",
                     out_result, out_rd, out_store_data, out_reg_write);
        end
        drive(mk('0, '0, 1'b0, 1'b0), 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        out_ready = 1'b1;
        drive(mk(32'h5, 5'd3, 1'b1, 1'b0), 1'b1);
        @(negedge clk);
        drive(mk('0, '0, 1'b0, 1'b0), 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h5 || out_rd !== 5'd3) begin
            n_fail++;
            $display("FAIL basic_out: valid=%b result=%h rd=%0d, want 1 5 3", out_valid, out_result, out_rd);
        end
        n_checks++;
        if (fwd_valid !== 1'b1 || fwd_data !== 32'h5 || fwd_rd !== 5'd3) begin
            n_fail++;
            $display("FAIL basic_fwd: fwd_valid=%b data=%h rd=%0d, want 1 5 3", fwd_valid, fwd_data, fwd_rd);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_drain: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(mk(32'h11, 5'd1, 1'b1, 1'b0), 1'b1);
        @(negedge clk);
        drive(mk(32'h22, 5'd2, 1'b1, 1'b0), 1'b1);
        @(negedge clk);
        drive(mk(32'h33, 5'd3, 1'b1, 1'b0), 1'b1);
        n_checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_result !== 32'h11) begin
            n_fail++;
            $display("FAIL bp_full: occ=%0d in_ready=%b result=%h, want 2 0 11", occupancy, in_ready, out_result);
        end
        @(negedge clk);
        n_checks++;
        if (occupancy !== 2'd2 || out_result !== 32'h11 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: occ=%0d result=%h valid=%b, want 2 11 1", occupancy, out_result, out_valid);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_result !== 32'h22 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_second: result=%h in_ready=%b occ=%0d, want 22 1 1", out_result, in_ready, occupancy);
        end
        @(negedge clk);
        drive(mk('0, '0, 1'b0, 1'b0), 1'b0);
        n_checks++;
        if (out_result !== 32'h33 || out_valid !== 1'b1 || occupancy !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_third: result=%h valid=%b occ=%0d, want 33 1 1", out_result, out_valid, occupancy);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_empty: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(mk(32'hA1, 5'd4, 1'b1, 1'b0), 1'b1);
        @(negedge clk);
        drive(mk(32'hA2, 5'd5, 1'b1, 1'b0), 1'b1);
        @(negedge clk);
        flush = 1'b1;
        drive(mk(32'h44, 5'd6, 1'b1, 1'b0), 1'b1);
        @(negedge clk);
        flush = 1'b0;
        drive(mk('0, '0, 1'b0, 1'b0), 1'b0);
        n_checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || fwd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: occ=%0d valid=%b in_ready=%b fwd=%b, want 0 0 1 0",
                     occupancy, out_valid, in_ready, fwd_valid);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_d: out_valid=%b result=%h, want 0", out_valid, out_result);
        end
    endtask

    task automatic test_forward();
        out_ready = 1'b1;
        drive(mk(32'h100, 5'd7, 1'b1, 1'b1), 1'b1);
        @(negedge clk);
        drive(mk(32'h200, 5'd0, 1'b1, 1'b0), 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || fwd_valid !== 1'b0 || out_mem_read !== 1'b1 || out_rd !== 5'd7) begin
            n_fail++;
            $display("FAIL fwd_load: valid=%b fwd=%b mem_read=%b rd=%0d, want 1 0 1 7",
                     out_valid, fwd_valid, out_mem_read, out_rd);
        end
        @(negedge clk);
        drive(mk('0, '0, 1'b0, 1'b0), 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || fwd_valid !== 1'b0 || out_result !== 32'h200 || out_reg_write !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_rd0: valid=%b fwd=%b result=%h rw=%b, want 1 0 200 1",
                     out_valid, fwd_valid, out_result, out_reg_write);
        end
        @(negedge clk);
        n_checks++;
        if (out_reg_write !== 1'b0 || out_mem_read !== 1'b0 || out_mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL ctrl_gate: rw=%b mr=%b mw=%b, want 0 0 0", out_reg_write, out_mem_read, out_mem_write);
        end
    endtask

    // Reference: a bounded FIFO of capacity 2 with 1-cycle latency.
    task automatic test_random();
        ent_t q[$];
        ent_t e;
        logic v, rdy, fl;
        int   bad = 0;
        drive(mk('0, '0, 1'b0, 1'b0), 1'b0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int cyc = 0; cyc < 10000; cyc++) begin
            // Compare DUT state against the model after the previous edge.
            n_checks++;
            if (out_valid !== (q.size() != 0) || occupancy !== 2'(q.size()) ||
                in_ready !== (q.size() < 2)) begin
                n_fail++; bad++;
                if (bad < 10)
                    $display("FAIL rand_ctrl cyc=%0d: valid=%b occ=%0d in_ready=%b, want %b %0d %b",
                             cyc, out_valid, occupancy, in_ready, q.size() != 0, q.size(), q.size() < 2);
            end
            if (q.size() != 0) begin
                n_checks++;
                if (out_result !== q[0].result || out_zero !== q[0].zero || out_store_data !== q[0].sd ||
                    out_rd !== q[0].rd || out_reg_write !== q[0].rw || out_mem_read !== q[0].mr ||
                    out_mem_write !== q[0].mw ||
                    fwd_valid !== (q[0].rw && !q[0].mr && q[0].rd != 0) || fwd_data !== q[0].result) begin
                    n_fail++; bad++;
                    if (bad < 10)
                        $display("FAIL rand_data cyc=%0d: result=%h rd=%0d fwd=%b, want %h %0d %b",
                                 cyc, out_result, out_rd, fwd_valid, q[0].result, q[0].rd,
                                 q[0].rw && !q[0].mr && q[0].rd != 0);
                end
            end else begin
                n_checks++;
                if (fwd_valid !== 1'b0 || out_reg_write !== 1'b0) begin
                    n_fail++; bad++;
                    if (bad < 10)
                        $display("FAIL rand_idle cyc=%0d: fwd=%b rw=%b, want 0 0", cyc, fwd_valid, out_reg_write);
                end
            end
            // New stimulus for the next edge, and the model's view of it.
            e.result = $urandom; e.zero = 1'($urandom); e.sd = $urandom;
            e.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            e.rw = 1'($urandom); e.mr = 1'($urandom); e.mw = 1'($urandom);
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 63) == 0);
            drive(e, v);
            out_ready = rdy;
            flush     = fl;
            if (fl) begin
                q.delete();
            end else begin
                logic acc;
                acc = v && (q.size() < 2);
                if (rdy && q.size() != 0) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            @(negedge clk);
        end
        flush = 1'b0;
        drive(mk('0, '0, 1'b0, 1'b0), 1'b0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(mk(32'h55, 5'd5, 1'b1, 1'b0), 1'b1);
        @(negedge clk);
        drive(mk(32'h66, 5'd6, 1'b1, 1'b0), 1'b1);
        @(negedge clk);
        drive(mk('0, '0, 1'b0, 1'b0), 1'b0);
        n_checks++;
        if (occupancy !== 2'd2 || fwd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: occ=%0d fwd=%b, want 2 1", occupancy, fwd_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || fwd_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_async: valid=%b fwd=%b occ=%0d in_ready=%b, want 0 0 0 1",
                     out_valid, fwd_valid, occupancy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_fail++;
            $display("FAIL areset_after: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_forward();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX→MEM pipeline stage directly downstream of the ALU.
- Captures the ALU result, the zero flag and the EX-stage control/data bundle, then presents them to the data-memory stage through a valid/ready handshake.
- Holds a 2-entry skid buffer so back-pressure from MEM never forces a combinational ready path back into EX.
- Also drives the EX forwarding bus for the instruction currently held at its output.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- REG_W, 5, width of destination register index.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  discard all held and incoming entries (branch/exception)
- in_valid  input  1  EX presents a valid instruction
- in_ready  output  1  stage can accept; registered, depends only on skid occupancy
- in_result  input  DATA_W  ALU result
- in_zero  input  1  ALU zero flag
- in_store_data  input  DATA_W  rt value for stores
- in_rd  input  REG_W  destination register
- in_reg_write  input  1  writes register file
- in_mem_read  input  1  load
- in_mem_write  input  1  store
- out_valid  output  1  output entry valid
- out_ready  input  1  MEM stage accepts
- out_result, out_zero, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write  output  (widths as inputs)  held entry
- fwd_valid  output  1  forwarding data usable by EX
- fwd_rd  output  REG_W  forwarded register index
- fwd_data  output  DATA_W  forwarded value
- occupancy  output  2  entries held (0..2)

Behaviour:
- Storage: main register (drives out_*) and skid register; each has a valid bit.
- Reset, asynchronous: both valid bits 0, all payload fields 0, in_ready=1, out_valid=0, fwd_valid=0, occupancy=0.
- Accept: in_fire = in_valid & in_ready. Drain: out_fire = out_valid & out_ready.
- in_ready = !skid_valid, taken from the flop only, never from out_ready.
- Latency: 1 cycle, in_fire at edge N gives out_valid at edge N+1 when the stage was empty.
- Order is strictly FIFO; payload never changes while out_valid=1 and out_ready=0.

Per-edge transitions (skid_valid, main_valid):
- (0,0): in_fire loads main.
- (0,1):
  - out_fire & in_fire: main ← input.
  - out_fire only: main empties.
  - in_fire only: input → skid.
- (1,1), where in_ready=0:
  - out_fire: main ← skid, skid empties.
  - otherwise hold.
- (1,0) is unreachable; the assertion checks it never occurs.
- occupancy = main_valid + skid_valid.

Flush:
- At the next edge, flush clears both valid bits.
- An in_fire in the same cycle is discarded.
- An out_fire in the same cycle still counts as delivered on that cycle.
- Flush has priority over all other transitions.
- Payload registers need not clear on flush.

Forwarding:
- fwd_valid = out_valid & out_reg_write & !out_mem_read & (out_rd != 0).
- fwd_rd = out_rd; fwd_data = out_result.
- Combinational from the main register.
- Loads never forward, so a load-use stall is the hazard unit's job.

Other rules:
- Control bits on an invalid entry are don't-care. out_reg_write, out_mem_read and out_mem_write are gated to 0 when out_valid=0.
- Reset asserted mid-transfer aborts immediately. Outputs return to reset values asynchronously; no partial entry survives.

Test Plan:
- Reset, then 1 cycle in_valid with result=0x0000_0005, rd=3, reg_write=1, out_ready=1 → out_valid high exactly next cycle with result 5, rd 3; fwd_valid=1, fwd_data=5.
- Hold out_ready=0, push A=0x11 then B=0x22 → occupancy 2, in_ready=0 on third cycle, C=0x33 not accepted; raise out_ready → A, B, C delivered in order, no loss or duplication.
- Full stage, flush=1 with in_valid=1 (D=0x44) and out_ready=0 → next cycle occupancy=0, out_valid=0, in_ready=1; D never appears.
- Load entry (mem_read=1, rd=7, result=0x100) → out_valid=1, fwd_valid=0. Entry with rd=0, reg_write=1 → fwd_valid=0.
- Random in_valid/out_ready for 10k cycles against a scoreboard FIFO → exact order and payloads match, occupancy ≤2, (skid_valid & !main_valid) never observed.
- Assert rst asynchronously between edges with occupancy=2 → out_valid, fwd_valid and occupancy go to 0 before the next clock edge; in_ready=1.
